// File: rtl/sw_pkg.sv
// Shared SpaceWire switch definitions: arbiter state encoding, default sizes,
// control-character codes and a clog2 helper.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SPILL = 2'd2
  } sw_arb_state_t;

  localparam int SW_PORTNUM = 16;
  // Data width of a SpaceWire character: control flag plus 8 data bits.
  localparam int SW_DW      = 9;

  localparam logic [SW_DW-1:0] SW_EOP = 9'h100;
  localparam logic [SW_DW-1:0] SW_EEP = 9'h101;

  function automatic int sw_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sw_out_port_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from N-1 back to 0.
module sw_rr_picker
  import sw_pkg::*;
#(
  parameter int N = SW_PORTNUM,
  parameter int W = sw_clog2(SW_PORTNUM)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = '0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so non-power-of-2 port counts work.
      k = {1'b0, ptr} + (W+1)'(i);
      if (k >= (W+1)'(N)) k = k - (W+1)'(N);
      if (!valid && req[k[W-1:0]]) begin
        valid               = 1'b1;
        idx                 = k[W-1:0];
        onehot[k[W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_out_port_arbiter.sv
// Per-output-port packet arbiter for the SpaceWire switch matrix.
// Optional two-class priority arbitration: define SW_ARB_PRIORITY_EN.
module sw_out_port_arbiter
  import sw_pkg::*;
#(
  parameter int PORTNUM = SW_PORTNUM,
  parameter int SELW    = sw_clog2(PORTNUM),
  parameter int TMO_W   = 16
) (
  input  logic               gclk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [PORTNUM-1:0] req_i,
  input  logic [PORTNUM-1:0] prio_i,
  input  logic               xfer_i,
  input  logic               eop_i,
  input  logic [TMO_W-1:0]   tmo_limit_i,
  output logic [PORTNUM-1:0] grant_o,
  output logic [SELW-1:0]    sel_o,
  output logic               busy_o,
  output logic [PORTNUM-1:0] spill_o,
  output logic               tmo_o
);

  sw_arb_state_t      state_q, state_d;
  logic [PORTNUM-1:0] grant_q, grant_d;
  logic [PORTNUM-1:0] spill_q, spill_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic [SELW-1:0]    rr_ptr, rr_d;
  logic [TMO_W-1:0]   tcnt, tcnt_d;

  logic [PORTNUM-1:0] pick_onehot;
  logic [SELW-1:0]    pick_idx;
  logic               pick_valid;
  logic [SELW-1:0]    ptr_inc;
  logic               tmo_hit;
  logic               pkt_end;

`ifdef SW_ARB_PRIORITY_EN
  logic [PORTNUM-1:0] hi_onehot, lo_onehot;
  logic [SELW-1:0]    hi_idx, lo_idx;
  logic               hi_valid, lo_valid;

  sw_rr_picker #(.N(PORTNUM), .W(SELW)) u_pick_hi (
    .req(req_i & prio_i), .ptr(rr_ptr),
    .onehot(hi_onehot), .idx(hi_idx), .valid(hi_valid)
  );
  sw_rr_picker #(.N(PORTNUM), .W(SELW)) u_pick_lo (
    .req(req_i), .ptr(rr_ptr),
    .onehot(lo_onehot), .idx(lo_idx), .valid(lo_valid)
  );

  assign pick_onehot = hi_valid ? hi_onehot : lo_onehot;
  assign pick_idx    = hi_valid ? hi_idx    : lo_idx;
  assign pick_valid  = hi_valid | lo_valid;
`else
  logic unused_prio;
  assign unused_prio = ^prio_i;

  sw_rr_picker #(.N(PORTNUM), .W(SELW)) u_pick (
    .req(req_i), .ptr(rr_ptr),
    .onehot(pick_onehot), .idx(pick_idx), .valid(pick_valid)
  );
`endif

  assign ptr_inc = (sel_q == SELW'(PORTNUM-1)) ? '0 : sel_q + SELW'(1);
  assign tmo_hit = (tmo_limit_i != '0) && (tcnt == tmo_limit_i - TMO_W'(1));
  assign pkt_end = xfer_i & eop_i;

  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      spill_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rr_ptr  <= '0;
      tcnt    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      spill_q <= spill_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      rr_ptr  <= rr_d;
      tcnt    <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    spill_d = spill_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    rr_d    = rr_ptr;
    tcnt_d  = tcnt;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (enable_i && pick_valid) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        // An EOP in the timeout cycle takes precedence over the spill.
        if (pkt_end) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = ptr_inc;
          tcnt_d  = '0;
        end else if (!xfer_i && tmo_hit) begin
          state_d = SPILL;
          grant_d = '0;
          spill_d = grant_q;
          tmo_d   = 1'b1;
          tcnt_d  = '0;
        end else if (xfer_i) begin
          tcnt_d = '0;
        end else if (tcnt != '1) begin
          tcnt_d = tcnt + TMO_W'(1);
        end
      end
      SPILL: begin
        if (pkt_end) begin
          state_d = IDLE;
          spill_d = '0;
          busy_d  = 1'b0;
          rr_d    = ptr_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        spill_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign busy_o  = busy_q;
  assign spill_o = spill_q;
  assign tmo_o   = tmo_q;

endmodule
